sdram_loader: RTL and testbench

- Upstream feeder for the SDRAM controller's loader/saver write port.
- Accepts the 16-bit ROM/BIOS download stream from the HPS ioctl interface and packs half-word pairs into 32-bit words.
- Buffers packed words in a small FIFO and issues them on the toggle-style ls_we_req/ls_we_ack handshake, applying ioctl_wait backpressure.
- Pulses done once a download has fully landed in SDRAM.

---
 rtl/sdram_pkg.sv | 17 +
 rtl/sdram_loader_chk.sv | 18 +
 rtl/sdram_loader_fifo.sv | 51 +++++
 rtl/sdram_loader.sv | 182 ++++++++++++++++++
 tb/tb_sdram_loader.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: bus widths, loader FSM states and the packed-word FIFO entry.
package sdram_pkg;
    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 32;
    localparam int SDRAM_WADDR_W = SDRAM_ADDR_W - 2;

    typedef enum logic [1:0] {
        LD_IDLE     = 2'd0,
        LD_ISSUE    = 2'd1,
        LD_WAIT_ACK = 2'd2
    } ld_state_t;

    typedef struct packed {
        logic [SDRAM_WADDR_W-1:0] word_addr;
        logic [SDRAM_DATA_W-1:0]  data;
    } fifo_entry_t;
endpackage

// File: rtl/sdram_loader_chk.sv
// Invariant checks for the loader FIFO: pushes never exceed free space, occupancy is consistent.
module sdram_loader_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             reset,
    input logic             push0,
    input logic             push1,
    input logic [CNT_W-1:0] count,
    input logic [CNT_W-1:0] free
);
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (int'(push0) + int'(push1)) <= int'(free));

    a_occupancy: assert property (@(posedge clk) disable iff (reset)
        (int'(count) + int'(free)) == DEPTH);
endmodule

// File: rtl/sdram_loader_fifo.sv
// First-word-fall-through FIFO of packed words; two pushes per cycle, push0 lands ahead of push1.
module sdram_loader_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push0,
    input  fifo_entry_t      din0,
    input  logic             push1,
    input  fifo_entry_t      din1,
    input  logic             pop,
    output fifo_entry_t      dout,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] free
);
    fifo_entry_t      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_s;

    assign pop_s = pop & (count_r != {CNT_W{1'b0}});
    assign dout  = mem_r[rd_ptr_r];
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;
    assign free  = CNT_W'(DEPTH) - count_r;

    // Storage write and pointer/occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push0) begin
                mem_r[wr_ptr_r] <= din0;
            end
            if (push1) begin
                mem_r[wr_ptr_r + PTR_W'(push0)] <= din1;
            end
            wr_ptr_r <= wr_ptr_r + PTR_W'(push0) + PTR_W'(push1);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
            count_r  <= count_r + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop_s);
        end
    end
endmodule

// File: rtl/sdram_loader.sv
// Packs the 16-bit ioctl download stream into 32-bit SDRAM loader writes on a toggle handshake.
// Define SDRAM_LOADER_CHECKSUM_EN to add a running 32-bit sum of issued words on `checksum`.
module sdram_loader
    import sdram_pkg::*;
#(
    parameter logic [SDRAM_ADDR_W-1:0] BASE_ADDR  = 25'h0000000,
    parameter int                      FIFO_DEPTH = 4,
    parameter logic [15:0]             PAD_VALUE  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    output logic [24:0] ls_waddr,
    output logic [31:0] ls_din,
    output logic        ls_we_req,
    input  logic        ls_we_ack,
    output logic        done,
`ifdef SDRAM_LOADER_CHECKSUM_EN
    output logic [31:0] checksum,
`endif
    output logic        busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ld_state_t                state_r;
    logic                     dl_prev_r, pend_r, ended_r, req_r, wait_r, done_r, busy_r;
    logic [SDRAM_WADDR_W-1:0] pend_addr_r;
    logic [15:0]              pend_low_r;
    logic [24:0]              waddr_r;
    logic [31:0]              din_r;

    logic                     wr_s, rise_s, fall_s, match_s, pop_s, empty_s, outstanding_s;
    logic                     push0_s, push1_s, addr_lsb_unused_s;
    logic [SDRAM_WADDR_W-1:0] wr_word_s;
    fifo_entry_t              din0_s, din1_s, head_s;
    logic [CNT_W-1:0]         count_s, free_s, free_next_s;

    assign wr_s              = ioctl_wr & ioctl_download;
    assign rise_s            = ioctl_download & ~dl_prev_r;
    assign fall_s            = dl_prev_r & ~ioctl_download;
    assign wr_word_s         = ioctl_addr[24:2];
    assign match_s           = pend_r & (pend_addr_r == wr_word_s);
    assign pop_s             = (state_r == LD_ISSUE);
    assign outstanding_s     = (req_r != ls_we_ack);
    assign addr_lsb_unused_s = ioctl_addr[0];
    assign free_next_s       = free_s - CNT_W'(push0_s) - CNT_W'(push1_s) + CNT_W'(pop_s);

    assign ioctl_wait = wait_r;
    assign ls_waddr   = waddr_r;
    assign ls_din     = din_r;
    assign ls_we_req  = req_r;
    assign done       = done_r;
    assign busy       = busy_r;

    // Half-word packing: an orphaned pending low half always goes out (padded) ahead of the new word.
    always_comb begin
        push0_s = 1'b0;
        push1_s = 1'b0;
        din0_s  = {pend_addr_r, PAD_VALUE, pend_low_r};
        din1_s  = {wr_word_s, ioctl_dout, PAD_VALUE};
        if (wr_s) begin
            if (!ioctl_addr[1]) begin
                push0_s = pend_r & ~match_s;
            end else if (match_s) begin
                push1_s = 1'b1;
                din1_s  = {wr_word_s, ioctl_dout, pend_low_r};
            end else begin
                push0_s = pend_r;
                push1_s = 1'b1;
            end
        end else if (fall_s) begin
            push0_s = pend_r;
        end else begin
            push0_s = 1'b0;
        end
    end

    sdram_loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push0 (push0_s),
        .din0  (din0_s),
        .push1 (push1_s),
        .din1  (din1_s),
        .pop   (pop_s),
        .dout  (head_s),
        .empty (empty_s),
        .count (count_s),
        .free  (free_s)
    );

    sdram_loader_chk #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_chk (
        .clk   (clk),
        .reset (reset),
        .push0 (push0_s),
        .push1 (push1_s),
        .count (count_s),
        .free  (free_s)
    );

    // Pending half, download-edge tracking, backpressure, busy and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_prev_r   <= 1'b0;
            pend_r      <= 1'b0;
            pend_addr_r <= {SDRAM_WADDR_W{1'b0}};
            pend_low_r  <= 16'h0000;
            ended_r     <= 1'b0;
            wait_r      <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            dl_prev_r <= ioctl_download;
            wait_r    <= (free_next_s <= CNT_W'(2));
            busy_r    <= ~empty_s | outstanding_s | pend_r | (state_r != LD_IDLE);
            done_r    <= 1'b0;
            if (wr_s) begin
                pend_r      <= ~ioctl_addr[1];
                pend_addr_r <= wr_word_s;
                pend_low_r  <= ioctl_dout;
            end else if (fall_s) begin
                pend_r <= 1'b0;
            end
            if (rise_s) begin
                ended_r <= 1'b0;
            end else if (fall_s) begin
                ended_r <= 1'b1;
            end else if (ended_r && empty_s && !outstanding_s && !pend_r && state_r == LD_IDLE) begin
                ended_r <= 1'b0;
                done_r  <= 1'b1;
            end
        end
    end

    // Issue FSM: one request in flight; address and data hold until the controller acks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= LD_IDLE;
            waddr_r <= 25'h0000000;
            din_r   <= 32'h00000000;
            req_r   <= 1'b0;
        end else begin
            case (state_r)
                LD_IDLE: begin
                    if (!empty_s && !outstanding_s) begin
                        state_r <= LD_ISSUE;
                    end
                end
                LD_ISSUE: begin
                    waddr_r <= BASE_ADDR + {head_s.word_addr, 2'b00};
                    din_r   <= head_s.data;
                    req_r   <= ~req_r;
                    state_r <= LD_WAIT_ACK;
                end
                LD_WAIT_ACK: begin
                    if (ls_we_ack == req_r) begin
                        state_r <= LD_IDLE;
                    end
                end
                default: state_r <= LD_IDLE;
            endcase
        end
    end

`ifdef SDRAM_LOADER_CHECKSUM_EN
    logic [31:0] csum_r;
    assign checksum = csum_r;

    // Running sum of issued words, restarted by each new download.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_r <= 32'h00000000;
        end else begin
            csum_r <= (rise_s ? 32'h00000000 : csum_r) + (pop_s ? head_s.data : 32'h00000000);
        end
    end
`endif
endmodule

// File: tb/tb_sdram_loader.sv
// Bench for sdram_loader: directed and random half-word streams against a packing model plus
// a behavioural SDRAM controller that acks requests after a random delay.
module tb_sdram_loader;
    localparam logic [24:0] TB_BASE = 25'h1FFFFFC;
    localparam logic [15:0] PAD     = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset, ioctl_download, ioctl_wr, ioctl_wait;
    logic [24:0] ioctl_addr, ls_waddr;
    logic [15:0] ioctl_dout;
    logic [31:0] ls_din;
    logic        ls_we_req, ls_we_ack, done, busy;
`ifdef SDRAM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;
    logic        hold_ack = 1'b0;
    logic [56:0] exp_q[$];
    logic [56:0] got_q[$];
    logic        mpend;
    logic [22:0] mpaddr;
    logic [15:0] mplow;
    logic [31:0] exp_sum;

    always #5 clk = ~clk;

    sdram_loader #(.BASE_ADDR(TB_BASE), .FIFO_DEPTH(4), .PAD_VALUE(PAD)) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wr       (ioctl_wr),
        .ioctl_wait     (ioctl_wait),
        .ls_waddr       (ls_waddr),
        .ls_din         (ls_din),
        .ls_we_req      (ls_we_req),
        .ls_we_ack      (ls_we_ack),
        .done           (done),
`ifdef SDRAM_LOADER_CHECKSUM_EN
        .checksum       (checksum),
`endif
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [22:0] word, input logic [31:0] data);
        logic [24:0] a;
        a = TB_BASE + {word, 2'b00};
        exp_q.push_back({a, data});
        exp_sum = exp_sum + data;
    endtask

    // Packing rules: a word is emitted when its high half arrives, or padded when orphaned.
    task automatic model_write(input logic [24:0] addr, input logic [15:0] d);
        logic [22:0] word;
        word = addr[24:2];
        if (!addr[1]) begin
            if (mpend && mpaddr != word) push_exp(mpaddr, {PAD, mplow});
            mpend = 1'b1;
            mpaddr = word;
            mplow = d;
        end else begin
            if (mpend && mpaddr == word) begin
                push_exp(word, {d, mplow});
            end else begin
                if (mpend) push_exp(mpaddr, {PAD, mplow});
                push_exp(word, {d, PAD});
            end
            mpend = 1'b0;
        end
    endtask

    task automatic hw_write(input logic [24:0] addr, input logic [15:0] d);
        int n = 0;
        while (ioctl_wait === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("wait_timeout", 64'd1, 64'd0);
        ioctl_addr = addr;
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
        model_write(addr, d);
    endtask

    task automatic start_dl();
        @(posedge clk); #1;
        ioctl_download = 1'b1;
        exp_sum = 32'h0;
    endtask

    task automatic end_dl(input string tag);
        int  n = 0;
        bit  seen = 1'b0;
        ioctl_download = 1'b0;
        if (mpend) push_exp(mpaddr, {PAD, mplow});
        mpend = 1'b0;
        while (!seen && n < 500) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done"}, 64'(seen), 64'd1);
`ifdef SDRAM_LOADER_CHECKSUM_EN
        check({tag, "_checksum"}, 64'(checksum), 64'(exp_sum));
`endif
        @(negedge clk);
        check({tag, "_done_single"}, 64'(done), 64'd0);
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
        check({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic wait_got(input string tag, input int want);
        int n = 0;
        while (got_q.size() < want && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_got"}, 64'(got_q.size()), 64'(want));
    endtask

    // Controller model: copies req into ack after a random delay, logging each request.
    initial begin
        int lat = 0;
        ls_we_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                ls_we_ack = 1'b0;
                lat = 0;
            end else if (!hold_ack && ls_we_req !== ls_we_ack) begin
                if (lat == 0) begin
                    got_q.push_back({ls_waddr, ls_din});
                    ls_we_ack = ls_we_req;
                    lat = int'($urandom_range(0, 3));
                end else begin
                    lat--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        logic        saw_wait;
        logic        req_before;
        int          dc_before;
        int          n;
        logic [24:0] a;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_addr = 25'h0;
        ioctl_dout = 16'h0;
        ioctl_wr = 1'b0;
        mpend = 1'b0;
        mpaddr = 23'h0;
        mplow = 16'h0;
        exp_sum = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req", 64'(ls_we_req), 64'd0);
        check("rst_waddr", 64'(ls_waddr), 64'd0);
        check("rst_din", 64'(ls_din), 64'd0);
        check("rst_wait", 64'(ioctl_wait), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Contiguous pair -> one word, req toggles 0 -> 1.
        start_dl();
        hw_write(25'h000, 16'h1234);
        hw_write(25'h002, 16'hABCD);
        wait_got("pair", 1);
        check("pair_req_toggle", 64'(ls_we_req), 64'd1);
        end_dl("pair");

        // Orphan low half, padded when the download ends.
        start_dl();
        hw_write(25'h010, 16'h5555);
        end_dl("orphan");

        // Skip-ahead: low half of one word, then high half of the next.
        start_dl();
        hw_write(25'h020, 16'h1111);
        hw_write(25'h026, 16'h2222);
        end_dl("skip");

        // Address wrap: word at byte 4 plus base 0x1FFFFFC lands at 0.
        start_dl();
        hw_write(25'h004, 16'h5A5A);
        hw_write(25'h006, 16'hA5A5);
        wait_got("wrap", 1);
        check("wrap_addr", 64'(got_q[0][56:32]), 64'd0);
        end_dl("wrap");

        // Backpressure: ack held while 12 half-words stream in.
        start_dl();
        hold_ack = 1'b1;
        saw_wait = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ioctl_wait === 1'b1 && hold_ack) begin
                saw_wait = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                check("bp_wait_held", 64'(ioctl_wait), 64'd1);
                hold_ack = 1'b0;
            end
            hw_write(25'h100 + 25'(i * 2), 16'(16'hC000 + i));
        end
        hold_ack = 1'b0;
        check("bp_wait_rose", 64'(saw_wait), 64'd1);
        end_dl("bp");

        // Random half-words over a small window of words.
        start_dl();
        for (int i = 0; i < 40; i++) begin
            a = 25'((32'h40 + $urandom_range(0, 5)) << 2) | 25'({$urandom_range(0, 1), 1'b0});
            hw_write(a, 16'($urandom));
        end
        end_dl("rand");

        // Restart before drain cancels the pending done.
        start_dl();
        hold_ack = 1'b1;
        hw_write(25'h300, 16'h0F0F);
        hw_write(25'h302, 16'hF0F0);
        dc_before = done_cnt;
        ioctl_download = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ioctl_download = 1'b1;
        exp_sum = 32'h0;
        hold_ack = 1'b0;
        repeat (30) @(negedge clk);
        check("cancel_no_done", 64'(done_cnt), 64'(dc_before));
        end_dl("cancel");

        // Writes outside the download window are ignored.
        req_before = ls_we_req;
        @(posedge clk); #1;
        ioctl_addr = 25'h400;
        ioctl_dout = 16'h7777;
        ioctl_wr = 1'b1;
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_wr_req", 64'(ls_we_req), 64'(req_before));
        check("idle_wr_busy", 64'(busy), 64'd0);
        check("idle_wr_got", 64'(got_q.size()), 64'd0);

`ifdef SDRAM_LOADER_CHECKSUM_EN
        start_dl();
        hw_write(25'h000, 16'h0001);
        hw_write(25'h002, 16'h0000);
        hw_write(25'h004, 16'hFFFF);
        hw_write(25'h006, 16'hFFFF);
        end_dl("csum");
        check("csum_zero", 64'(checksum), 64'd0);
`endif

        // Reset while a request waits for its ack.
        start_dl();
        hold_ack = 1'b1;
        hw_write(25'h200, 16'h1357);
        hw_write(25'h202, 16'h2468);
        hw_write(25'h204, 16'h9999);
        n = 0;
        while (ls_we_req === ls_we_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_outstanding", 64'(ls_we_req !== ls_we_ack), 64'd1);
        dc_before = done_cnt;
        @(posedge clk); #1;
        reset = 1'b1;
        ioctl_download = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_req", 64'(ls_we_req), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_wait", 64'(ioctl_wait), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        hold_ack = 1'b0;
        mpend = 1'b0;
        exp_q.delete();
        got_q.delete();
        repeat (10) @(negedge clk);
        check("rstmid_fifo_empty", 64'(ls_we_req), 64'd0);
        check("rstmid_busy_after", 64'(busy), 64'd0);
        check("rstmid_no_done", 64'(done_cnt), 64'(dc_before));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
